seq_mult_32: RTL and testbench
==============================

// Module: seq_mult_32
// PURPOSE
//  Unsigned 32x32 -> 64-bit shift-and-add multiplier. One iteration per clock.
//  Sits downstream of the 32-bit ripple adder (adderSubtractor):
//   - instantiates it as its only datapath adder;
//   - consumes its S/co each cycle to build the partial product.
//  Start/busy/done handshake to the controlling sequencer.
// PARAMETERS
//  WIDTH    32  operand width; only 32 is supported (the adder is fixed at 32 bits)
//  CNT_W     6  iteration-counter width; must hold 0..WIDTH
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   asynchronous reset, active-high
//  start    in   1   request; sampled only in IDLE
//  a        in  32   multiplicand; latched when start is accepted
//  b        in  32   multiplier; latched when start is accepted
//  busy     out  1   high while an operation is in progress (RUN state)
//  done     out  1   one-cycle pulse: product is valid
//  product  out 64   result; held until the next accepted start
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE; busy=0, done=0, product=0.
//   - Internal acc, mq, mcand and cnt cleared.
//   - Takes effect immediately, including mid-RUN; the in-flight operation is discarded.
//  Registers: mcand[31:0], acc[31:0] (high half), mq[31:0] (low half / multiplier), cnt[CNT_W-1:0].
//  Adder: A=acc, B=mcand, cin=0 -> {co,S}. Sum is used only when mq[0]=1.
//  States:
//   - IDLE: start=1 at edge E0 -> mcand=a, mq=b, acc=0, cnt=0, go RUN. busy=1 after E0.
//   - RUN: each edge E1..E32 performs one iteration:
//       mq[0]=1 -> {acc,mq} <= {co,S,mq[31:1]}
//       mq[0]=0 -> {acc,mq} <= {1'b0,acc,mq[31:1]}
//       cnt <= cnt+1
//     At the edge where cnt==31 (E32), the final iteration also sets:
//       product={acc_next,mq_next}, done=1, busy=0, state->IDLE.
//   - done is registered and high exactly one cycle (E32..E33).
//  Latency: product valid 32 clocks after the start-accepting edge. Throughput: one op per 33 cycles.
//  Handshake rules:
//   - start while busy=1 is ignored; operands are not re-latched.
//   - start high in the done cycle is accepted; the next op begins and the product register is kept.
//   - start held high continuously -> back-to-back ops, one per 33 cycles.
//  Arithmetic:
//   - Carry-out co is the 33rd bit of each partial sum and shifts into acc[31]; no overflow is possible.
//   - 64-bit product is exact for all unsigned inputs.
//  product changes only on the completing edge of RUN or on reset; it is stable otherwise.
//  a/b may change freely after acceptance without affecting the running op.
// TESTING
//  1. a=3, b=5, start 1 cycle -> busy 32 cycles; done pulse at E32; product=64'd15.
//  2. a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 (exercises co every cycle).
//  3. a=0, b=32'h1234_5678 and a=32'h8000_0000, b=2 -> product=0 and 64'h1_0000_0000.
//  4. Start at E0 with a=7, b=6; pulse start again at E10 with a=9, b=9 -> ignored; product=42.
//  5. Assert rst at E15 of a run -> busy, done, product go 0 immediately.
//     Release rst, then a=2, b=3 -> product=6 after 32 cycles.
//  6. start held high: first op a=10, b=10, then a=11, b=11 accepted on done cycle.
//     -> product=100 with done at E32; product=121 with done 33 cycles later.

Source files
------------

// File: rtl/seq_mult_32.sv
// Unsigned 32x32 -> 64-bit shift-and-add multiplier, one iteration per clock,
// built around the 32-bit ripple adder defined below.

module adderSubtractor #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] s_o,
    output logic         co_o
);

    // Ripple carry chain; sub_i inverts B and injects the +1 carry-in.
    always_comb begin
        logic c;
        logic bx;
        s_o = '0;
        c   = sub_i;
        bx  = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            bx     = b_i[i] ^ sub_i;
            s_o[i] = a_i[i] ^ bx ^ c;
            c      = (a_i[i] & bx) | (c & (a_i[i] ^ bx));
        end
        co_o = c;
    end

endmodule

module seq_mult_32 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   sum;
    logic               co;

    adderSubtractor #(.W(WIDTH)) u_add (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .sub_i (1'b0),
        .s_o   (sum),
        .co_o  (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Carry-out lands in acc MSB so the 65-bit partial sum never overflows.
                if (mq_q[0]) begin
                    {acc_d, mq_d} = {co, sum, mq_q[WIDTH-1:1]};
                end else begin
                    {acc_d, mq_d} = {1'b0, acc_q, mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = {acc_d, mq_d};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_32.sv
// Scoreboard bench for seq_mult_32: driver pushes expected products and done
// cycles, a negedge monitor pops and compares whenever done is seen.

module tb_seq_mult_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   cyc;

    seq_mult_32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done cycle=%0d product=%h", cyc, product);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", product, e.prod);
                check("done_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Drive start for one cycle at a negedge and record the reference result.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        e.prod = 64'(x) * 64'(y);
        e.due  = cyc + 1 + 32;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count busy over the remaining run, ending on the done cycle.
    task automatic finish_op(input int already_busy);
        int nb;
        nb = already_busy;
        if (busy) nb++;
        repeat (31) begin
            @(negedge clk);
            if (busy) nb++;
        end
        @(negedge clk);
        check("busy_len", 64'(nb), 64'(32));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y);
        start_op(x, y);
        finish_op(0);
    endtask

    initial begin
        int nb;
        exp_t e;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", product, 64'(0));
        rst = 1'b0;

        run_op(32'd3, 32'd5);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd0, 32'h1234_5678);
        run_op(32'h8000_0000, 32'd2);

        // Second start while busy must be ignored.
        start_op(32'd7, 32'd6);
        nb = 1;
        repeat (9) begin
            @(negedge clk);
            if (busy) nb++;
        end
        a = 32'd9;
        b = 32'd9;
        start = 1'b1;
        @(negedge clk);
        if (busy) nb++;
        start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy) nb++;
        end
        finish_op(nb - 1);

        // Reset mid-run discards the operation immediately.
        start_op(32'd123, 32'd456);
        repeat (14) @(negedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_product", product, 64'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd2, 32'd3);

        // Start held high: second op accepted in the done cycle.
        @(negedge clk);
        a     = 32'd10;
        b     = 32'd10;
        start = 1'b1;
        e.prod = 64'd100;
        e.due  = cyc + 1 + 32;
        exp_q.push_back(e);
        e.prod = 64'd121;
        e.due  = cyc + 1 + 33 + 32;
        exp_q.push_back(e);
        @(negedge clk);
        a = 32'd11;
        b = 32'd11;
        repeat (33) @(negedge clk);
        check("b2b_done_cycle_busy", 64'(busy), 64'(1));
        start = 1'b0;
        repeat (33) @(negedge clk);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom);
        end
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'd1, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk);
        check("pending_ops", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
